// File: rtl/capture_pkg.sv
// Shared types and constants for the ping-pong frame capture sequencer.
// Holds the FSM state enum, MCU register addresses and CTRL bit indices.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      CAPTURE   = 2'd2,
      SWAP      = 2'd3
   } cap_state_t;

   localparam logic [1:0] CFG_CTRL    = 2'd0;
   localparam logic [1:0] CFG_SAMPLES = 2'd1;
   localparam logic [1:0] CFG_DECIM   = 2'd2;

   localparam int CTRL_ARM  = 0;
   localparam int CTRL_CONT = 1;

endpackage

// File: rtl/capture_sequencer_if.sv
// Bundle of all non-clock signals of the capture sequencer.
// slave: the sequencer (ADC/MCU inputs in, buffer/status out); master: its environment.
interface capture_sequencer_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 10
);
   logic              stable;
   logic              signal_in;
   logic              sample_stb;
   logic [DATA_W-1:0] adc_data;
   logic              cfg_we;
   logic [1:0]        cfg_addr;
   logic [15:0]       cfg_wdata;
   logic              mcu_done;
   logic              buf_wr_en;
   logic [ADDR_W-1:0] buf_wr_addr;
   logic [DATA_W-1:0] buf_wr_data;
   logic              buf_wr_sel;
   logic              buf_rd_sel;
   logic              ready;
   logic              overrun;
   logic [1:0]        state_o;

   modport slave (
      input  stable, signal_in, sample_stb, adc_data,
      input  cfg_we, cfg_addr, cfg_wdata, mcu_done,
      output buf_wr_en, buf_wr_addr, buf_wr_data,
      output buf_wr_sel, buf_rd_sel, ready, overrun, state_o
   );

   modport master (
      output stable, signal_in, sample_stb, adc_data,
      output cfg_we, cfg_addr, cfg_wdata, mcu_done,
      input  buf_wr_en, buf_wr_addr, buf_wr_data,
      input  buf_wr_sel, buf_rd_sel, ready, overrun, state_o
   );

endinterface

// File: rtl/sample_decimator.sv
// Keeps 1 of every DECIM+1 samples; DECIM is shadowed on load (frame start).
// Ports: clk, rst, load, decim, en (capturing), sample_stb -> keep (same cycle as stb).
module sample_decimator #(
   parameter int DEC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DEC_W-1:0] decim,
   input  logic             en,
   input  logic             sample_stb,
   output logic             keep
);

   logic [DEC_W-1:0] dec_sh;
   logic [DEC_W-1:0] dec_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_sh  <= '0;
         dec_cnt <= '0;
      end else if (load) begin
         dec_sh  <= decim;
         dec_cnt <= '0;
      end else if (en && sample_stb) begin
         dec_cnt <= (dec_cnt == dec_sh) ? '0 : dec_cnt + DEC_W'(1);
      end
   end

   assign keep = en && sample_stb && (dec_cnt == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Ping-pong ADC frame capture: arm, wait for rising edge, write decimated frame, swap.
// Ports: clk, rst (sync, active-high), bus (capture_sequencer_if.slave).
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 10,
   parameter int DEC_W  = 8
) (
   input logic                 clk,
   input logic                 rst,
   capture_sequencer_if.slave  bus
);

   cap_state_t        state;
   cap_state_t        state_nx;
   logic [1:0]        ctrl;
   logic [ADDR_W:0]   samples;
   logic [DEC_W-1:0]  decim;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] addr;
   logic              sig_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_sel;
   logic              rd_sel;
   logic              ready;
   logic              overrun;
   logic              keep;
   logic              abort;
   logic              go;
   logic              cap_en;
   logic              last_wr;
   logic              ready_eff;
   logic              ctrl_wr;
   logic              unused_ok;

   assign unused_ok = ^bus.cfg_wdata[15:ADDR_W+1];

   // Abort only matters while in WAIT_EDGE/CAPTURE.
   assign abort   = !bus.stable || !ctrl[CTRL_ARM];
   assign go      = (state == WAIT_EDGE) && !abort
                    && bus.signal_in && !sig_d;
   assign cap_en  = (state == CAPTURE) && !abort;
   assign last_wr = keep && (addr == last_addr);
   assign ctrl_wr = bus.cfg_we && (bus.cfg_addr == CFG_CTRL);
   // mcu_done in the SWAP cycle frees the read buffer first.
   assign ready_eff = ready && !bus.mcu_done;

   sample_decimator #(.DEC_W(DEC_W)) u_dec (
      .clk        (clk),
      .rst        (rst),
      .load       (go),
      .decim      (decim),
      .en         (cap_en),
      .sample_stb (bus.sample_stb),
      .keep       (keep)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (ctrl[CTRL_ARM] && bus.stable) state_nx = WAIT_EDGE;
         WAIT_EDGE:
            if (abort)   state_nx = IDLE;
            else if (go) state_nx = CAPTURE;
         CAPTURE:
            if (abort)        state_nx = IDLE;
            else if (last_wr) state_nx = SWAP;
         SWAP:
            state_nx = ctrl[CTRL_CONT] ? WAIT_EDGE : IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl    <= '0;
         samples <= '0;
         decim   <= '0;
      end else begin
         if (state == SWAP && !ctrl[CTRL_CONT]) ctrl[CTRL_ARM] <= 1'b0;
         if (bus.cfg_we) begin
            case (bus.cfg_addr)
               CFG_CTRL:    ctrl    <= bus.cfg_wdata[1:0];
               CFG_SAMPLES: samples <= bus.cfg_wdata[ADDR_W:0];
               CFG_DECIM:   decim   <= bus.cfg_wdata[DEC_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // 0 wraps to all-ones and anything >= 2**ADDR_W clamps to a full buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_d     <= 1'b0;
         last_addr <= '0;
         addr      <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         sig_d <= bus.signal_in;
         wr_en <= keep;
         if (go) begin
            addr      <= '0;
            last_addr <= samples[ADDR_W] ? '1
                         : samples[ADDR_W-1:0] - ADDR_W'(1);
         end else if (keep) begin
            addr <= addr + ADDR_W'(1);
         end
         if (keep) begin
            wr_addr <= addr;
            wr_data <= bus.adc_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b1;
         ready   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (bus.mcu_done) ready <= 1'b0;
         if (ctrl_wr) overrun <= 1'b0;
         if (state == SWAP) begin
            if (!ready_eff) begin
               rd_sel <= wr_sel;
               wr_sel <= !wr_sel;
               ready  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

   assign bus.buf_wr_en   = wr_en;
   assign bus.buf_wr_addr = wr_addr;
   assign bus.buf_wr_data = wr_data;
   assign bus.buf_wr_sel  = wr_sel;
   assign bus.buf_rd_sel  = rd_sel;
   assign bus.ready       = ready;
   assign bus.overrun     = overrun;
   assign bus.state_o     = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed testbench for capture_sequencer.
// Drives stimulus after each rising edge and checks registered outputs 1 time unit later.
module tb_capture_sequencer;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   capture_sequencer_if #(.DATA_W(12), .ADDR_W(10)) bus ();

   capture_sequencer #(
      .DATA_W (12),
      .ADDR_W (10),
      .DEC_W  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic done_pulse();
      bus.mcu_done = 1'b1;
      tick();
      bus.mcu_done = 1'b0;
   endtask

   // Call while in WAIT_EDGE; leaves signal_in high.
   task automatic edge_in();
      bus.signal_in = 1'b0;
      tick();
      bus.signal_in = 1'b1;
      tick();
      chk("edge_state", bus.state_o, 2);
   endtask

   task automatic stb(input logic [11:0] d, input bit exp_en,
                      input int exp_addr);
      bus.sample_stb = 1'b1;
      bus.adc_data   = d;
      tick();
      bus.sample_stb = 1'b0;
      chk("wr_en", bus.buf_wr_en, exp_en);
      if (exp_en) begin
         chk("wr_addr", bus.buf_wr_addr, exp_addr);
         chk("wr_data", bus.buf_wr_data, d);
      end
      tick();
      chk("wr_en_gap", bus.buf_wr_en, 0);
   endtask

   task automatic chk_bufs(input string tag, input bit rdy, input bit rd,
                           input bit wr, input bit ovr, input int st);
      chk({tag, "_ready"}, bus.ready, rdy);
      chk({tag, "_rd_sel"}, bus.buf_rd_sel, rd);
      chk({tag, "_wr_sel"}, bus.buf_wr_sel, wr);
      chk({tag, "_overrun"}, bus.overrun, ovr);
      chk({tag, "_state"}, bus.state_o, st);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst            = 1'b1;
      bus.stable     = 1'b1;
      bus.signal_in  = 1'b0;
      bus.sample_stb = 1'b0;
      bus.adc_data   = '0;
      bus.cfg_we     = 1'b0;
      bus.cfg_addr   = '0;
      bus.cfg_wdata  = '0;
      bus.mcu_done   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_wr_en", bus.buf_wr_en, 0);
      chk("rst_wr_addr", bus.buf_wr_addr, 0);
      chk("rst_wr_data", bus.buf_wr_data, 0);
      chk_bufs("rst", 0, 1, 0, 0, 0);
      tick();
      chk("rst_idle_hold", bus.state_o, 0);

      // 1) basic frame of 8, no decimation
      cfg_write(2'd1, 16'd8);
      cfg_write(2'd2, 16'd0);
      cfg_write(2'd0, 16'd1);
      chk("t1_armed_idle", bus.state_o, 0);
      tick();
      chk("t1_wait", bus.state_o, 1);
      edge_in();
      for (int i = 0; i < 8; i++) stb(12'(5 + i), 1'b1, i);
      chk_bufs("t1", 1, 0, 1, 0, 0);
      tick();
      tick();
      chk("t1_arm_cleared", bus.state_o, 0);
      done_pulse();
      chk("t1_done", bus.ready, 0);

      // 2) DECIM=2, SAMPLES=4: keep 0,3,6,9
      cfg_write(2'd2, 16'd2);
      cfg_write(2'd1, 16'd4);
      cfg_write(2'd0, 16'd1);
      tick();
      edge_in();
      for (int i = 0; i < 12; i++)
         stb(12'(i), (i % 3 == 0) && (i < 10), i / 3);
      chk_bufs("t2", 1, 1, 0, 0, 0);

      // 3) continuous, overrun on second frame
      done_pulse();
      cfg_write(2'd2, 16'd0);
      cfg_write(2'd0, 16'd3);
      tick();
      edge_in();
      for (int i = 0; i < 4; i++) stb(12'(20 + i), 1'b1, i);
      chk_bufs("t3a", 1, 0, 1, 0, 1);
      edge_in();
      for (int i = 0; i < 4; i++) stb(12'(30 + i), 1'b1, i);
      chk_bufs("t3b", 1, 0, 1, 1, 1);
      cfg_write(2'd0, 16'd0);
      chk("t3_ovr_clr", bus.overrun, 0);
      tick();
      chk("t3_disarm", bus.state_o, 0);

      // 4) mcu_done coincides with SWAP
      cfg_write(2'd0, 16'd1);
      tick();
      edge_in();
      for (int i = 0; i < 3; i++) stb(12'(40 + i), 1'b1, i);
      bus.sample_stb = 1'b1;
      bus.adc_data   = 12'd43;
      tick();
      bus.sample_stb = 1'b0;
      chk("t4_swap_state", bus.state_o, 3);
      chk("t4_wr_en", bus.buf_wr_en, 1);
      chk("t4_wr_addr", bus.buf_wr_addr, 3);
      bus.mcu_done = 1'b1;
      tick();
      bus.mcu_done = 1'b0;
      chk_bufs("t4", 1, 1, 0, 0, 0);

      // 5) stable drop aborts; re-arm restarts at addr 0
      cfg_write(2'd1, 16'd8);
      cfg_write(2'd0, 16'd1);
      tick();
      edge_in();
      for (int i = 0; i < 3; i++) stb(12'(50 + i), 1'b1, i);
      bus.stable = 1'b0;
      tick();
      chk_bufs("t5_abort", 1, 1, 0, 0, 0);
      bus.stable = 1'b1;
      done_pulse();
      cfg_write(2'd0, 16'd1);
      chk("t5_ready_clr", bus.ready, 0);
      edge_in();
      stb(12'd100, 1'b1, 0);
      stb(12'd101, 1'b1, 1);
      cfg_write(2'd0, 16'd1);
      chk("t5_no_restart", bus.state_o, 2);
      for (int i = 2; i < 8; i++) stb(12'(100 + i), 1'b1, i);
      chk_bufs("t5", 1, 0, 1, 0, 0);

      // 6) SAMPLES=0 -> full 1024; SAMPLES write mid-frame is shadowed
      done_pulse();
      cfg_write(2'd1, 16'd0);
      cfg_write(2'd0, 16'd1);
      tick();
      edge_in();
      for (int i = 0; i < 1024; i++) begin
         stb(12'(i), 1'b1, i);
         if (i == 10) cfg_write(2'd1, 16'd4);
         if (i == 1022) chk("t6_still_cap", bus.state_o, 2);
      end
      chk_bufs("t6", 1, 1, 0, 0, 0);

      // 7) reset mid-capture
      cfg_write(2'd0, 16'd1);
      tick();
      edge_in();
      stb(12'd7, 1'b1, 0);
      stb(12'd8, 1'b1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7_wr_addr", bus.buf_wr_addr, 0);
      chk("t7_wr_data", bus.buf_wr_data, 0);
      chk_bufs("t7", 0, 1, 0, 0, 0);
      tick();
      tick();
      chk("t7_idle_hold", bus.state_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
